// File: rtl/fc_train_seq_if.sv
// Host-side sample/result handshake plus the fc layer-stack forward/backward control bundle.
interface fc_train_seq_if #(
  parameter int N = 27
);
  localparam int CW = $clog2(N + 1);

  logic          s_valid_in;
  logic          s_ready_out;
  logic [N-1:0]  s_x_in;
  logic [N-1:0]  s_target_in;
  logic          s_train_in;
  logic [N-1:0]  fin_out;
  logic          fd_prop_out;
  logic [N-1:0]  fout_in;
  logic          fd_prop_done_in;
  logic [N-1:0]  bin_out;
  logic          bk_prop_out;
  logic          bk_prop_done_in;
  logic          m_valid_out;
  logic          m_ready_in;
  logic [N-1:0]  m_pred_out;
  logic [CW-1:0] m_err_cnt_out;
  logic          m_timeout_out;

  // master = the sequencer, slave = host + fc stack
  modport master (
    input  s_valid_in, s_x_in, s_target_in, s_train_in, fout_in, fd_prop_done_in,
           bk_prop_done_in, m_ready_in,
    output s_ready_out, fin_out, fd_prop_out, bin_out, bk_prop_out, m_valid_out,
           m_pred_out, m_err_cnt_out, m_timeout_out
  );
  modport slave (
    output s_valid_in, s_x_in, s_target_in, s_train_in, fout_in, fd_prop_done_in,
           bk_prop_done_in, m_ready_in,
    input  s_ready_out, fin_out, fd_prop_out, bin_out, bk_prop_out, m_valid_out,
           m_pred_out, m_err_cnt_out, m_timeout_out
  );
endinterface

// File: rtl/fc_train_seq.sv
// One-sample-in-flight sequencer: forward pass, optional backward pass on the error vector, result out.
module fc_train_seq #(
  parameter int N       = 27,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  fc_train_seq_if.master bus
);
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMAX  = {TW{1'b1}};

  typedef enum logic [2:0] {IDLE, FSTART, FWAIT, BSTART, BWAIT, DONE} state_t;

  state_t        state;
  logic          s_ready, fd_prop, bk_prop, m_valid, timeout, train;
  logic [N-1:0]  fin, tgt, bin, pred, err;
  logic [TW-1:0] timer;
  logic [CW-1:0] err_cnt;

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < N; i++) err_cnt = err_cnt + CW'(err[i]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      fd_prop <= 1'b0;
      bk_prop <= 1'b0;
      m_valid <= 1'b0;
      timeout <= 1'b0;
      train   <= 1'b0;
      fin     <= '0;
      tgt     <= '0;
      bin     <= '0;
      pred    <= '0;
      err     <= '0;
      timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_valid_in && s_ready) begin
            fin     <= bus.s_x_in;
            tgt     <= bus.s_target_in;
            train   <= bus.s_train_in;
            s_ready <= 1'b0;
            fd_prop <= 1'b1;
            state   <= FSTART;
          end else begin
            s_ready <= 1'b1;
          end
        end
        FSTART: begin
          fd_prop <= 1'b0;
          timer   <= '0;
          state   <= FWAIT;
        end
        FWAIT: begin
          // done beats a timeout expiring on the same cycle
          if (bus.fd_prop_done_in) begin
            pred <= bus.fout_in;
            err  <= bus.fout_in ^ tgt;
            if (train) begin
              bin     <= bus.fout_in ^ tgt;
              bk_prop <= 1'b1;
              state   <= BSTART;
            end else begin
              m_valid <= 1'b1;
              state   <= DONE;
            end
          end else if (timer == TLAST) begin
            timeout <= 1'b1;
            pred    <= '0;
            err     <= '0;
            m_valid <= 1'b1;
            state   <= DONE;
          end else if (timer != TMAX) begin
            timer <= timer + 1'b1;
          end
        end
        BSTART: begin
          bk_prop <= 1'b0;
          timer   <= '0;
          state   <= BWAIT;
        end
        BWAIT: begin
          if (bus.bk_prop_done_in) begin
            m_valid <= 1'b1;
            state   <= DONE;
          end else if (timer == TLAST) begin
            timeout <= 1'b1;
            m_valid <= 1'b1;
            state   <= DONE;
          end else if (timer != TMAX) begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          // s_ready rises with the return to IDLE, so the earliest new accept is the next cycle
          if (bus.m_ready_in) begin
            m_valid <= 1'b0;
            bin     <= '0;
            timeout <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready_out   = s_ready;
  assign bus.fin_out       = fin;
  assign bus.fd_prop_out   = fd_prop;
  assign bus.bin_out       = bin;
  assign bus.bk_prop_out   = bk_prop;
  assign bus.m_valid_out   = m_valid;
  assign bus.m_pred_out    = pred;
  assign bus.m_err_cnt_out = err_cnt;
  assign bus.m_timeout_out = timeout;
endmodule
